// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states
// and the request record layout used at the default ALU width.
package alu_seq_pkg;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] ADC = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] INC = 3'd3;
  localparam logic [2:0] DEC = 3'd4;
  localparam logic [2:0] CMP = 3'd5;
  localparam logic [2:0] SHL = 3'd6;
  localparam logic [2:0] SHR = 3'd7;

  localparam int unsigned ALU_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } seq_state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Synchronous request FIFO with show-ahead head output; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module alu_req_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PTR_ONE;
      if (pop  && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Host-side sequencer: queues ALU requests, issues one enable pulse per op,
// captures the registered result/flags and returns them on a response stream.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_en,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic [2:0]   rsp_op,
  output logic [15:0]  op_count
);

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  seq_state_t state;
  seq_state_t state_n;

  req_t head;
  req_t req_in;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic issue;
  logic capture;
  logic done;

  assign req_in    = '{op: req_op, a: req_a, b: req_b};
  // Readiness is plain not-full: a pop in the same cycle does not free a slot early.
  assign req_ready = !fifo_full;

  alu_req_fifo #(
    .WIDTH($bits(req_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid),
    .pop  (pop),
    .din  (req_in),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        capture = 1'b1;
        state_n = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            issue   = 1'b1;
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
      op_count   <= '0;
    end else begin
      alu_en <= issue;
      if (issue) begin
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_op <= head.op;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_op     <= alu_op;
        rsp_valid  <= 1'b1;
      end else if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [N-1:0] req_a = '0;
  logic [N-1:0] req_b = '0;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic         alu_en;
  logic [N-1:0] alu_result = '0;
  logic         alu_carry = 1'b0;
  logic         alu_zero = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] rsp_result;
  logic         rsp_carry, rsp_zero;
  logic [2:0]   rsp_op;
  logic [15:0]  op_count;

  alu_op_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_op(rsp_op), .op_count(op_count)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ALU behaviour: returns {carry_out, result}; CMP/SHL/SHR keep the held carry.
  function automatic logic [N:0] alu_eval(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic cin);
    logic [N:0] s;
    case (op)
      ADD:     s = {1'b0, a} + {1'b0, b};
      ADC:     s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      SUB:     s = {(a < b), a - b};
      INC:     s = {1'b0, a} + (N+1)'(1);
      DEC:     s = {(a == '0), a - N'(1)};
      CMP:     s = {cin, (a < b) ? N'(1) : ((a == b) ? N'(2) : N'(4))};
      SHL:     s = {cin, a << 1};
      default: s = {cin, a >> 1};
    endcase
    return s;
  endfunction

  always @(posedge clk) begin : alu_model
    logic [N:0] s;
    if (alu_en) begin
      s = alu_eval(alu_op, alu_a, alu_b, alu_carry);
      alu_result <= s[N-1:0];
      alu_carry  <= s[N];
      alu_zero   <= (s[N-1:0] == '0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and protocol monitors, sampled on the falling edge.
  alu_req_t     q[$];
  int           hs_cyc[$];
  logic         model_c = 1'b0;
  int           acc_since_rst = 0;
  int           en_pulses = 0, adj_viol = 0, busy_viol = 0, stall_viol = 0;
  logic         en_prev = 1'b0, hold_prev = 1'b0;
  logic [N-1:0] h_res;
  logic         h_c, h_z;
  logic [2:0]   h_op;

  always @(negedge clk) begin : monitor
    logic [N:0] ev;
    alu_req_t   h;
    if (hold_prev && !rst) begin
      if (!rsp_valid || rsp_result != h_res || rsp_carry != h_c || rsp_zero != h_z || rsp_op != h_op)
        stall_viol++;
    end
    if (rst) begin
      q.delete();
      acc_since_rst = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        hs_cyc.push_back(cyc);
        if (q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
        else begin
          h  = q.pop_front();
          ev = alu_eval(h.op, h.a, h.b, model_c);
          chk("sb_result", 32'(rsp_result), 32'(ev[N-1:0]));
          chk("sb_carry",  32'(rsp_carry),  32'(ev[N]));
          chk("sb_zero",   32'(rsp_zero),   32'(ev[N-1:0] == '0));
          chk("sb_op",     32'(rsp_op),     32'(h.op));
          model_c = ev[N];
        end
      end
      if (req_valid && req_ready) begin
        q.push_back('{op: req_op, a: req_a, b: req_b});
        acc_since_rst++;
      end
    end
    if (alu_en) begin
      en_pulses++;
      if (en_prev) adj_viol++;
      if (rsp_valid) busy_viol++;
    end
    en_prev   = alu_en;
    hold_prev = rsp_valid && !rsp_ready && !rst;
    h_res = rsp_result; h_c = rsp_carry; h_z = rsp_zero; h_op = rsp_op;
  end

  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    bit done = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (req_ready) done = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic get_rsp(output logic [N-1:0] r, output logic c, output logic z, output logic [2:0] op);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    if (!seen) chk("rsp_timeout", 0, 1);
    r = rsp_result; c = rsp_carry; z = rsp_zero; op = rsp_op;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b, res;
    logic         c, z;
  } vec_t;

  vec_t         vt[14];
  logic [N-1:0] r;
  logic         c, z;
  logic [2:0]   o;
  logic [N:0]   ev;
  int           lat, en_at, acc, p0, highs;
  bit           seen;

  initial begin
    vt[0]  = '{ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vt[1]  = '{ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[2]  = '{ADC, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0};
    vt[3]  = '{CMP, 8'h03, 8'h09, 8'h01, 1'b0, 1'b0};
    vt[4]  = '{CMP, 8'h07, 8'h07, 8'h02, 1'b0, 1'b0};
    vt[5]  = '{CMP, 8'h09, 8'h03, 8'h04, 1'b0, 1'b0};
    vt[6]  = '{SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vt[7]  = '{SHR, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0};
    vt[8]  = '{INC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[9]  = '{DEC, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[10] = '{DEC, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[11] = '{SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0};
    vt[12] = '{ADC, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vt[13] = '{SUB, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu_en",    32'(alu_en), 0);
    chk("rst_op_count",  32'(op_count), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // First-op latency and operand hold
    req_valid = 1'b1; req_op = ADD; req_a = 8'hF0; req_b = 8'h20;
    @(negedge clk);
    chk("lat_req_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; en_at = -1; seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (alu_en) en_at = lat;
      if (rsp_valid) seen = 1;
    end
    chk("lat_rsp_valid_cycle", 32'(lat), 4);
    chk("lat_alu_en_cycle",    32'(en_at), 2);
    chk("lat_result", 32'(rsp_result), 8'h10);
    chk("lat_carry",  32'(rsp_carry), 1);
    chk("lat_zero",   32'(rsp_zero), 0);
    chk("lat_op",     32'(rsp_op), 0);
    chk("hold_alu_a", 32'(alu_a), 8'hF0);
    chk("hold_alu_b", 32'(alu_b), 8'h20);
    @(posedge clk); #1;

    // Table-driven vectors with hand-computed expectations
    foreach (vt[i]) begin
      send(vt[i].op, vt[i].a, vt[i].b);
      get_rsp(r, c, z, o);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].res));
      chk($sformatf("vec%0d_carry", i),  32'(c), 32'(vt[i].c));
      chk($sformatf("vec%0d_zero", i),   32'(z), 32'(vt[i].z));
      chk($sformatf("vec%0d_op", i),     32'(o), 32'(vt[i].op));
    end
    chk("vec_op_count", 32'(op_count), 15);

    // Back-pressure: one in service plus DEPTH queued
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_op = 3'($urandom); req_a = N'($urandom); req_b = N'($urandom);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("stall_accepted", 32'(acc), DEPTH + 1);
    p0 = en_pulses;
    repeat (6) @(negedge clk);
    chk("stall_req_ready", 32'(req_ready), 0);
    chk("stall_rsp_valid", 32'(rsp_valid), 1);
    chk("stall_no_issue",  32'(en_pulses - p0), 0);
    ev = alu_eval(q[0].op, q[0].a, q[0].b, model_c);
    chk("stall_head_result", 32'(rsp_result), 32'(ev[N-1:0]));
    chk("stall_head_op",     32'(rsp_op), 32'(q[0].op));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();
    chk("stall_op_count", 32'(op_count), 32'(16'(acc_since_rst)));

    // Reset while a SHL sits in CAPTURE
    send(SHL, 8'h81, 8'h00);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (alu_en) seen = 1;
    end
    chk("rstcap_issue_seen", 32'(seen), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstcap_alu_en",     32'(alu_en), 0);
    chk("rstcap_alu_a",      32'(alu_a), 0);
    chk("rstcap_alu_b",      32'(alu_b), 0);
    chk("rstcap_alu_op",     32'(alu_op), 0);
    chk("rstcap_rsp_valid",  32'(rsp_valid), 0);
    chk("rstcap_rsp_result", 32'(rsp_result), 0);
    chk("rstcap_rsp_carry",  32'(rsp_carry), 0);
    chk("rstcap_rsp_zero",   32'(rsp_zero), 0);
    chk("rstcap_rsp_op",     32'(rsp_op), 0);
    chk("rstcap_op_count",   32'(op_count), 0);
    chk("rstcap_req_ready",  32'(req_ready), 1);
    highs = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) highs++;
    end
    chk("rstcap_no_response", 32'(highs), 0);
    @(posedge clk); #1;
    send(SHR, 8'h81, 8'h00);
    get_rsp(r, c, z, o);
    chk("post_rst_shr_result", 32'(r), 8'h40);
    chk("post_rst_shr_op",     32'(o), 32'(SHR));

    // Three back-to-back INCs: pulse count and 3-cycle throughput
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hs_cyc.delete();
    p0 = en_pulses;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = INC; req_a = N'(8'h7F * i); req_b = '0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    chk("inc_en_pulses", 32'(en_pulses - p0), 3);
    chk("inc_op_count",  32'(op_count), 3);
    chk("inc_rsp_count", 32'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      chk("inc_spacing_1", 32'(hs_cyc[1] - hs_cyc[0]), 3);
      chk("inc_spacing_2", 32'(hs_cyc[2] - hs_cyc[1]), 3);
    end

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom);
      req_a     = ($urandom_range(0, 7) == 0) ? 8'hFF : N'($urandom);
      req_b     = ($urandom_range(0, 7) == 0) ? req_a : N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("rand_op_count", 32'(op_count), 32'(16'(acc_since_rst)));

    chk("inv_alu_en_adjacent", 32'(adj_viol), 0);
    chk("inv_issue_while_rsp", 32'(busy_viol), 0);
    chk("inv_rsp_stable",      32'(stall_viol), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Host-side controller that drives the 8-bit ALU's operand/op-code/enable interface and collects its registered result and flags. Accepts operation requests over a valid/ready stream into a small request FIFO. Issues each request to the ALU as a single enable pulse, captures result, carry and zero, and returns them over a valid/ready response stream. Sits between the command source (test host or microcontroller) and the ALU instance.

Parameters:
N, 8, operand/result width; must match the ALU's N
DEPTH, 4, request FIFO entries; power of two, at least 2

Ports:
clk  in  1  rising-edge clock, shared with the ALU
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_op  in  3  op code (ADD=0, ADC=1, SUB=2, INC=3, DEC=4, CMP=5, SHL=6, SHR=7)
req_a  in  N  operand A
req_b  in  N  operand B
alu_a  out  N  to ALU A, registered
alu_b  out  N  to ALU B, registered
alu_op  out  3  to ALU op_code, registered
alu_en  out  1  to ALU en, registered single-cycle pulse
alu_result  in  N  from ALU result_out
alu_carry  in  1  from ALU flag_carry
alu_zero  in  1  from ALU flag_zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  N  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_op  out  3  op code of this response
op_count  out  16  completed responses, wraps modulo 2^16

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied; state IDLE; alu_en=0; alu_a/alu_b/alu_op=0; rsp_valid=0; rsp_result=0; rsp_carry=0; rsp_zero=0; rsp_op=0; op_count=0. Reset applies mid-operation with no exceptions; an in-flight op is dropped without a response.
- The ALU has no reset. Its internal carry persists across our reset and feeds the next ADC. This is documented and is not corrected here.
- req_ready = FIFO not full. Push occurs on req_valid && req_ready. req_ready does not look ahead at a same-cycle pop, so a full FIFO rejects the request even while popping.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE with FIFO non-empty: pop the head; load alu_a/b/op; alu_en<=1; go to ISSUE. IDLE with FIFO empty: stay.
  - ISSUE: the ALU samples en=1 at this edge. alu_en<=0; go to CAPTURE.
  - CAPTURE: rsp_result<=alu_result, rsp_carry<=alu_carry, rsp_zero<=alu_zero, rsp_op<=alu_op; rsp_valid<=1; go to RESP.
  - RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid && rsp_ready: rsp_valid<=0; op_count++.
    - If the FIFO is non-empty, go directly to the IDLE-pop action (load operands, alu_en<=1, go to ISSUE).
    - Otherwise go to IDLE.
- Latency: rsp_valid is first high 3 cycles after the first cycle the FIFO is non-empty in IDLE. Back-to-back throughput is one op per 3 cycles with rsp_ready held at 1.
- Exactly one op is outstanding at the ALU at any time. While a response is pending, nothing is issued. alu_en is never high for two consecutive cycles.
- alu_a/b/op hold their last values when alu_en=0.
- Flags pass through unmodified. carry is meaningful only for ops 0-4; for CMP/SHL/SHR it reports the ALU's held carry.
- With rsp_ready=0 and a continuous request stream, exactly DEPTH+1 requests are accepted: one in service plus DEPTH in the FIFO.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full is asserted when the MSBs differ and the remaining bits are equal.

Decomposition:
- Package alu_seq_pkg holds:
  - the op-code localparams ADD..SHR, shared with the ALU;
  - the FSM state enumeration;
  - the request struct {op, a, b}.
- One sub-module, alu_req_fifo: synchronous FIFO parameterised by width and DEPTH, with push/pop/full/empty ports and the same clk/rst.

Test Plan:
- ADD A=0xF0 B=0x20, rsp_ready=1 -> rsp_result=0x10, carry=1, zero=0, rsp_op=0; rsp_valid 3 cycles after FIFO non-empty.
- Consecutive ADD 0xFF+0x01 then ADC 0x01+0x01 -> first: result 0x00, carry=1, zero=1; second: result 0x03, carry=0, zero=0.
- CMP pairs (3,9), (7,7), (9,3) -> rsp_result 1, 2, 4 respectively, in order, with op_count ending at 3.
- Hold rsp_ready=0, drive 8 requests -> exactly 5 accepted, req_ready low thereafter. rsp_* stable and alu_en low while stalled. Releasing rsp_ready drains 5 responses in FIFO order.
- Assert rst during CAPTURE of a SHL A=0x81 -> no response emitted. All outputs at reset values the next cycle. A subsequent SHR A=0x81 returns 0x40.
- Stream of 3 INC ops with rsp_ready=1 -> alu_en pulses exactly 3 times, never on adjacent cycles. op_count=3.
